// File: rtl/obj_ram_dma_copier_pkg.sv
// Shared types for the object RAM copier: FSM state encoding.
package obj_ram_dma_copier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/obj_ram_dma_copier.sv
// Copies LEN words from a 1-cycle-latency source SRAM into a destination SRAM,
// one word per cycle unless held, once per accepted start pulse.
module obj_ram_dma_copier
    import obj_ram_dma_copier_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN        = 1024,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic                  src_cen,
    input  logic [DATA_WIDTH-1:0] src_q,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_cen,
    output logic                  dst_we,
    output logic [1:0]            dbg_state
);

    localparam int                  CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]       LAST      = CW'(LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] SRC_START = ADDR_WIDTH'(SRC_BASE);
    localparam logic [ADDR_WIDTH-1:0] DST_START = ADDR_WIDTH'(DST_BASE);

    state_t          state;
    logic [CW-1:0]   count;
    logic            rd_issued;

    // Handshake: a read is issued in any READ cycle with hold low; its data is
    // on src_q the next cycle, where rd_issued turns it into a destination write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_addr  <= SRC_START;
            dst_addr  <= DST_START;
            count     <= '0;
            rd_issued <= 1'b0;
        end else begin
            done      <= 1'b0;
            rd_issued <= 1'b0;
            if (rd_issued) begin
                dst_addr <= dst_addr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_READ;
                        busy     <= 1'b1;
                        count    <= '0;
                        src_addr <= SRC_START;
                        dst_addr <= DST_START;
                    end
                end
                ST_READ: begin
                    if (!hold) begin
                        rd_issued <= 1'b1;
                        src_addr  <= src_addr + 1'b1;
                        count     <= count + 1'b1;
                        if (count == LAST) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final write lands on this edge, so DONE follows directly.
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign src_cen   = (state == ST_READ) && !hold;
    assign dst_we    = rd_issued;
    assign dst_cen   = rd_issued;
    assign dst_data  = src_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_obj_ram_dma_copier.sv
// Bench for obj_ram_dma_copier: full copy, hold, wrap, start-while-busy, mid-copy reset, LEN=1.
module tb_obj_ram_dma_copier;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int W  = AW + DW;
  localparam logic [7:0] SENT = 8'h5A;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tie0 = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] src_mem [1024];
  logic [DW-1:0] dst_f [1024];
  logic [DW-1:0] dst_w [1024];
  logic [DW-1:0] dst_o [1024];

  logic [W-1:0] exp_q_f[$];
  logic [W-1:0] exp_q_w[$];
  logic [W-1:0] exp_q_o[$];

  // full-size instance
  logic start_f = 1'b0, hold_f = 1'b0;
  logic busy_f, done_f, src_cen_f, dst_cen_f, dst_we_f;
  logic [AW-1:0] src_addr_f, dst_addr_f;
  logic [DW-1:0] src_q_f, dst_data_f;
  logic [1:0] dbg_f;

  // wrapping instance
  logic start_w = 1'b0;
  logic busy_w, done_w, src_cen_w, dst_cen_w, dst_we_w;
  logic [AW-1:0] src_addr_w, dst_addr_w;
  logic [DW-1:0] src_q_w, dst_data_w;
  logic [1:0] dbg_w;

  // single-word instance
  logic start_o = 1'b0;
  logic busy_o, done_o, src_cen_o, dst_cen_o, dst_we_o;
  logic [AW-1:0] src_addr_o, dst_addr_o;
  logic [DW-1:0] src_q_o, dst_data_o;
  logic [1:0] dbg_o;

  obj_ram_dma_copier u_full (
    .clk(clk), .reset(reset), .start(start_f), .hold(hold_f),
    .busy(busy_f), .done(done_f), .src_addr(src_addr_f), .src_cen(src_cen_f),
    .src_q(src_q_f), .dst_addr(dst_addr_f), .dst_data(dst_data_f),
    .dst_cen(dst_cen_f), .dst_we(dst_we_f), .dbg_state(dbg_f)
  );

  obj_ram_dma_copier #(.SRC_BASE(1020), .DST_BASE(1022), .LEN(8)) u_wrap (
    .clk(clk), .reset(reset), .start(start_w), .hold(tie0),
    .busy(busy_w), .done(done_w), .src_addr(src_addr_w), .src_cen(src_cen_w),
    .src_q(src_q_w), .dst_addr(dst_addr_w), .dst_data(dst_data_w),
    .dst_cen(dst_cen_w), .dst_we(dst_we_w), .dbg_state(dbg_w)
  );

  obj_ram_dma_copier #(.LEN(1)) u_one (
    .clk(clk), .reset(reset), .start(start_o), .hold(tie0),
    .busy(busy_o), .done(done_o), .src_addr(src_addr_o), .src_cen(src_cen_o),
    .src_q(src_q_o), .dst_addr(dst_addr_o), .dst_data(dst_data_o),
    .dst_cen(dst_cen_o), .dst_we(dst_we_o), .dbg_state(dbg_o)
  );

  // synchronous SRAM models: registered read, write on clock edge
  always @(posedge clk) begin
    if (src_cen_f) src_q_f <= src_mem[src_addr_f];
    if (src_cen_w) src_q_w <= src_mem[src_addr_w];
    if (src_cen_o) src_q_o <= src_mem[src_addr_o];
    if (dst_cen_f && dst_we_f) dst_f[dst_addr_f] <= dst_data_f;
    if (dst_cen_w && dst_we_w) dst_w[dst_addr_w] <= dst_data_w;
    if (dst_cen_o && dst_we_o) dst_o[dst_addr_o] <= dst_data_o;
  end

  function automatic logic [7:0] pat(input int a);
    logic [7:0] lo;
    lo = 8'(a % 1024);
    return lo ^ 8'hA5;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // scoreboard monitors: every destination write must match the next expected word
  always @(negedge clk) begin
    if (dst_we_f) begin
      if (exp_q_f.size() == 0) fail_now("sb_full_extra_write");
      else cmp("sb_full", 32'({dst_addr_f, dst_data_f}), 32'(exp_q_f.pop_front()));
    end
    if (dst_we_w) begin
      if (exp_q_w.size() == 0) fail_now("sb_wrap_extra_write");
      else cmp("sb_wrap", 32'({dst_addr_w, dst_data_w}), 32'(exp_q_w.pop_front()));
    end
    if (dst_we_o) begin
      if (exp_q_o.size() == 0) fail_now("sb_one_extra_write");
      else cmp("sb_one", 32'({dst_addr_o, dst_data_o}), 32'(exp_q_o.pop_front()));
    end
  end

  typedef struct packed {
    logic start;
    logic busy;
    logic done;
    logic we;
    logic cen;
  } vec_t;
  vec_t tbl [6];

  // mode 0: plain copy; mode 1: hold pattern plus a start while busy
  task automatic run_full(input int mode);
    int busy_n, done_at, done_seen, bad;
    logic [3:0] hold_pat;
    hold_pat = 4'b1001;
    busy_n = 0; done_at = 0; done_seen = 0; bad = 0;
    for (int i = 0; i < 1024; i++) dst_f[i] = SENT;
    for (int i = 0; i < 1024; i++) exp_q_f.push_back({AW'(i), pat(i)});
    start_f = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (busy_f) busy_n++;
      if (done_f) begin
        done_seen++;
        if (done_at == 0) done_at = n;
      end
      if (mode == 1 && n == 6) begin
        cmp("hold_src_frozen", 32'(src_addr_f), 32'd4);
        cmp("hold_no_we_after_hold", 32'(dst_we_f), 32'd0);
      end
      if (mode == 1 && n == 7) cmp("hold_we_resumes", 32'(dst_we_f), 32'd1);
      if (mode == 1 && n == 9) cmp("hold_src_frozen2", 32'(src_addr_f), 32'd6);
      start_f = (mode == 1 && n == 300);
      hold_f = (mode == 1 && n >= 5 && n <= 8) ? hold_pat[n-5] : 1'b0;
      if (!busy_f && done_seen > 0) break;
    end
    hold_f = 1'b0;
    start_f = 1'b0;
    cmp($sformatf("full%0d_done_count", mode), 32'(done_seen), 32'd1);
    cmp($sformatf("full%0d_done_cycle", mode), 32'(done_at), (mode == 1) ? 32'd1028 : 32'd1026);
    cmp($sformatf("full%0d_busy_len", mode), 32'(busy_n), (mode == 1) ? 32'd1028 : 32'd1026);
    cmp($sformatf("full%0d_sb_empty", mode), 32'(exp_q_f.size()), 32'd0);
    for (int i = 0; i < 1024; i++) if (dst_f[i] !== pat(i)) bad++;
    cmp($sformatf("full%0d_dst_bad_words", mode), 32'(bad), 32'd0);
  endtask

  initial begin
    int bad, found, done_seen;
    for (int i = 0; i < 1024; i++) begin
      src_mem[i] = pat(i);
      dst_f[i] = SENT;
      dst_w[i] = SENT;
      dst_o[i] = SENT;
    end

    // reset block
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp("rst_busy", 32'(busy_f), 32'd0);
    cmp("rst_done", 32'(done_f), 32'd0);
    cmp("rst_src_addr", 32'(src_addr_f), 32'd0);
    cmp("rst_src_cen", 32'(src_cen_f), 32'd0);
    cmp("rst_dst_addr", 32'(dst_addr_f), 32'd0);
    cmp("rst_dst_we", 32'(dst_we_f), 32'd0);
    cmp("rst_wrap_src_addr", 32'(src_addr_w), 32'd1020);
    cmp("rst_wrap_dst_addr", 32'(dst_addr_w), 32'd1022);

    // LEN=1 cycle table; start in DONE (row 3) must be ignored
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_q_o.push_back({AW'(0), pat(0)});
    for (int i = 0; i < 6; i++) begin
      cmp($sformatf("one_busy_%0d", i), 32'(busy_o), 32'(tbl[i].busy));
      cmp($sformatf("one_done_%0d", i), 32'(done_o), 32'(tbl[i].done));
      cmp($sformatf("one_we_%0d", i), 32'(dst_we_o), 32'(tbl[i].we));
      cmp($sformatf("one_cen_%0d", i), 32'(src_cen_o), 32'(tbl[i].cen));
      start_o = tbl[i].start;
      @(negedge clk);
    end
    start_o = 1'b0;
    cmp("one_dst0", 32'(dst_o[0]), 32'(pat(0)));
    cmp("one_dst1_untouched", 32'(dst_o[1]), 32'(SENT));
    cmp("one_sb_empty", 32'(exp_q_o.size()), 32'd0);

    // address wrap
    for (int i = 0; i < 8; i++) exp_q_w.push_back({AW'((1022 + i) % 1024), pat((1020 + i) % 1024)});
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    found = 0;
    for (int n = 0; n < 50; n++) begin
      if (done_w) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    cmp("wrap_done_seen", 32'(found), 32'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (dst_w[(1022 + i) % 1024] !== pat((1020 + i) % 1024)) bad++;
    cmp("wrap_dst_bad_words", 32'(bad), 32'd0);
    cmp("wrap_dst6_untouched", 32'(dst_w[6]), 32'(SENT));
    cmp("wrap_dst1021_untouched", 32'(dst_w[1021]), 32'(SENT));
    cmp("wrap_sb_empty", 32'(exp_q_w.size()), 32'd0);

    // full copy, then hold pattern with a start while busy (second copy after done)
    @(negedge clk);
    run_full(0);
    repeat (2) @(negedge clk);
    run_full(1);
    repeat (2) @(negedge clk);

    // reset mid-copy: reset lands on the edge that writes word 99
    for (int i = 0; i < 1024; i++) dst_f[i] = SENT;
    for (int i = 0; i < 1024; i++) exp_q_f.push_back({AW'(i), pat(i)});
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    found = 0;
    for (int n = 0; n < 400; n++) begin
      if (dst_we_f && dst_addr_f == AW'(99)) begin
        reset = 1'b1;
        found = 1;
        break;
      end
      @(negedge clk);
    end
    cmp("mid_reset_reached_word", 32'(found), 32'd1);
    @(negedge clk);
    exp_q_f.delete();
    reset = 1'b0;
    cmp("mid_reset_dst_we", 32'(dst_we_f), 32'd0);
    cmp("mid_reset_busy", 32'(busy_f), 32'd0);
    cmp("mid_reset_src_addr", 32'(src_addr_f), 32'd0);
    cmp("mid_reset_dst_addr", 32'(dst_addr_f), 32'd0);
    done_seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (done_f || busy_f) done_seen++;
      @(negedge clk);
    end
    cmp("mid_reset_no_done", 32'(done_seen), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) if (dst_f[i] !== pat(i)) bad++;
    cmp("mid_reset_written_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 100; i < 1024; i++) if (dst_f[i] !== SENT) bad++;
    cmp("mid_reset_untouched_bad", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
